// File: rtl/dshot_output.sv
// DShot150 transmitter: appends the 4-bit DShot CRC to {value, telemetry}
// and serialises the 16-bit frame MSB-first as pulse-width-coded bits.
// Ports: clk/reset (sync, active-high); value/telemetry/send in, ready out;
//        dshot_out serial line (idles low); done pulses once after each gap;
//        frame holds the last accepted frame for debug.
module dshot_output #(
    parameter int CLK_HZ     = 16000000,
    parameter int BAUD       = 150000,
    parameter int T1H_CYCLES = 80,
    parameter int T0H_CYCLES = 40,
    parameter int GAP_BITS   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] value,
    input  logic        telemetry,
    input  logic        send,
    output logic        ready,
    output logic        dshot_out,
    output logic        done,
    output logic [15:0] frame
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
    localparam int CNT_MAX    = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);
    localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);

    // The decoder samples the line a quarter bit in; a '0' must still be
    // high there, so T0H has to exceed BIT_CYCLES/4.
    if (!(T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
          T0H_CYCLES > BIT_CYCLES / 4)) begin : g_bad_timing
        $error("dshot_output: illegal bit timing parameters");
    end

    typedef enum logic [1:0] {IDLE, BIT, GAP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      idx, idx_n;
    logic [15:0]     frame_n;
    logic            out_n;
    logic            done_n;
    logic [11:0]     payload;
    logic [3:0]      crc;

    // crc = (p ^ p>>4 ^ p>>8)[3:0], i.e. the XOR of the three nibbles.
    assign payload = {value, telemetry};
    assign crc     = payload[3:0] ^ payload[7:4] ^ payload[11:8];

    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            frame     <= '0;
            dshot_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            frame     <= frame_n;
            dshot_out <= out_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        frame_n = frame;
        done_n  = 1'b0;
        out_n   = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    state_n = BIT;
                    cnt_n   = '0;
                    idx_n   = 4'd15;
                    frame_n = {payload, crc};
                end
            end
            BIT: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (idx == 4'd0) state_n = GAP;
                    else             idx_n   = idx - 4'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // The output is computed from the next-cycle state so that the
        // registered pin lines up exactly with the registered counter.
        if (state_n == BIT)
            out_n = (cnt_n < (frame_n[idx_n] ? T1H : T0H));
    end

endmodule

// File: tb/tb_dshot_output.sv
module tb_dshot_output;

    localparam int BITC  = 106;
    localparam int GAPC  = 212;
    localparam int FRAMC = 16 * BITC;
    localparam int DONEK = FRAMC + GAPC;   // cycle index (0 = first BIT cycle) of done

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] value;
    logic        telemetry;
    logic        send;
    logic        ready;
    logic        dshot_out;
    logic        done;
    logic [15:0] frame;

    int tests = 0;
    int fails = 0;

    dshot_output dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .telemetry (telemetry),
        .send      (send),
        .ready     (ready),
        .dshot_out (dshot_out),
        .done      (done),
        .frame     (frame)
    );

    always #31 clk = ~clk;

    typedef struct {
        logic [10:0] v;
        logic        t;
        logic [15:0] exp_frame;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference CRC from the DShot rule: XOR of the three nibbles of {value,telem}.
    function automatic logic [15:0] model_frame(input logic [10:0] v, input logic t);
        int p, c;
        p = {20'd0, v, t};
        c = ((p) ^ (p / 16) ^ (p / 256)) % 16;
        return 16'((p * 16) + c);
    endfunction

    // Expected pin level k cycles after the accept edge (k=0 is first high cycle).
    function automatic logic model_pin(input logic [15:0] f, input int k);
        int b, w;
        if (k >= FRAMC) return 1'b0;
        b = 15 - k / BITC;
        w = f[b] ? 80 : 40;
        return (k % BITC) < w;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 4000) begin tick(); n++; end
        if (!ready) begin
            $display("FAIL %s: ready timeout got 0 expected 1", name);
            fails++; tests++;
        end
    endtask

    // Send one frame and check the whole waveform, widths, done, ready, frame.
    // If poke is set, a send with a different value is pulsed mid-frame and must be dropped.
    task automatic run_frame(input string name, input logic [10:0] v, input logic t,
                             input logic [15:0] exp_frame, input bit poke);
        int   bad_pin = 0, bad_rdy = 0, bad_done = 0;
        int   widths[16];
        int   decoded = 0;
        wait_ready(name);
        value = v; telemetry = t; send = 1'b1;
        tick();
        send = 1'b0;
        value = ~v; telemetry = ~t;       // inputs may change freely after accept
        check({name, " frame"}, frame, exp_frame);
        for (int i = 0; i < 16; i++) widths[i] = 0;
        for (int k = 0; k <= DONEK; k++) begin
            if (dshot_out !== model_pin(exp_frame, k)) bad_pin++;
            if (ready !== (k >= DONEK)) bad_rdy++;
            if (done !== (k == DONEK)) bad_done++;
            if (k < FRAMC && dshot_out) widths[k / BITC]++;
            if (poke && k == 500) send = 1'b1;
            if (poke && k == 503) send = 1'b0;
            if (k < DONEK) tick();
        end
        check({name, " pin errors"}, bad_pin, 0);
        check({name, " ready errors"}, bad_rdy, 0);
        check({name, " done errors"}, bad_done, 0);
        check({name, " frame hold"}, frame, exp_frame);
        // Loopback decode: width above half a bit is a '1'.
        for (int i = 0; i < 16; i++) decoded = decoded * 2 + ((widths[i] > BITC / 2) ? 1 : 0);
        check({name, " decoded"}, decoded, exp_frame);
        check({name, " width b15"}, widths[0], exp_frame[15] ? 80 : 40);
        tick();
        check({name, " done one-shot"}, done, 0);
    endtask

    initial begin
        reset = 1'b1; value = '0; telemetry = 1'b0; send = 1'b0;
        vecs[0] = '{11'd1046, 1'b0, 16'h82C6};
        vecs[1] = '{11'd0,    1'b1, 16'h0011};
        vecs[2] = '{11'd2047, 1'b1, 16'hFFFF};
        vecs[3] = '{11'd48,   1'b0, 16'h0606};
        tick(); tick();
        // Reset takes priority over a simultaneous send.
        send = 1'b1; tick(); send = 1'b0;
        check("reset ready", ready, 1);
        check("reset pin", dshot_out, 0);
        check("reset done", done, 0);
        check("reset frame", frame, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            check($sformatf("model v%0d", i), model_frame(vecs[i].v, vecs[i].t), vecs[i].exp_frame);
            run_frame($sformatf("vec%0d", i), vecs[i].v, vecs[i].t, vecs[i].exp_frame, i == 0);
        end

        // Loopback speed: throttle field minus 48 for value 1046.
        begin
            logic [15:0] f;
            f = model_frame(11'd1046, 1'b0);
            check("loopback speed", int'(f[15:5]) - 48, 998);
            check("loopback crc", f[3:0], f[15:12] ^ f[11:8] ^ f[7:4]);
        end

        for (int r = 0; r < 3; r++) begin
            logic [10:0] rv;
            logic        rt;
            rv = 11'($urandom_range(0, 2047));
            rt = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", r), rv, rt, model_frame(rv, rt), 1'b0);
        end

        // Reset during bit 7 (ninth bit transmitted).
        wait_ready("rst");
        value = 11'd1046; telemetry = 1'b0; send = 1'b1;
        tick(); send = 1'b0;
        repeat (8 * BITC + 30) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrst pin", dshot_out, 0);
        check("midrst ready", ready, 1);
        check("midrst frame", frame, 0);
        begin
            int spurious = 0;
            for (int k = 0; k < 300; k++) begin
                if (done || dshot_out) spurious++;
                tick();
            end
            check("midrst no done", spurious, 0);
        end
        run_frame("postrst", 11'd1046, 1'b0, 16'h82C6, 1'b0);

        // send held high: accepts exactly 1909 apart, ready low 1908 per frame.
        begin
            int acc[$];
            int low_run = 0, bad_run = 0, runs = 0;
            value = 11'd300; telemetry = 1'b1; send = 1'b1;
            for (int c = 0; c < 5000; c++) begin
                if (ready) begin
                    acc.push_back(c);
                    if (low_run != 0) begin
                        runs++;
                        if (low_run != DONEK) bad_run++;
                    end
                    low_run = 0;
                end else low_run++;
                tick();
            end
            send = 1'b0;
            check("hold accepts", acc.size(), 3);
            for (int i = 1; i < acc.size(); i++)
                check($sformatf("hold spacing%0d", i), acc[i] - acc[i-1], DONEK + 1);
            check("hold ready runs", runs, 2);
            check("hold ready bad", bad_run, 0);
            check("hold frame", frame, model_frame(11'd300, 1'b1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dshot_output.md
Name: dshot_output

Overview:
- DShot150 transmitter; the counterpart to the team's DShot input decoder.
- Accepts an 11-bit throttle/command value plus a telemetry-request bit over a valid/ready handshake.
- Appends the 4-bit DShot CRC and serialises the 16-bit frame MSB-first as pulse-width-coded bits on a single output pin.
- Drives ESC signal lines from the 16 MHz FPGA fabric clock; also used as loopback stimulus for the input decoder.

Parameters:
- CLK_HZ, 16000000, fabric clock frequency in Hz.
- BAUD, 150000, DShot bit rate. BIT_CYCLES = CLK_HZ/BAUD (integer divide) = 106.
- T1H_CYCLES, 80, high time of a '1' bit in clk cycles (about 75%).
- T0H_CYCLES, 40, high time of a '0' bit in clk cycles (about 37.5%).
- GAP_BITS, 2, minimum low inter-frame gap in bit periods. GAP_CYCLES = GAP_BITS*BIT_CYCLES = 212.

Ports:
- clk  in  1  fabric clock.
- reset  in  1  synchronous, active-high reset.
- value  in  11  raw DShot value field: 0-47 are special commands, 48-2047 are throttle.
- telemetry  in  1  telemetry request bit.
- send  in  1  request to transmit; qualified by ready.
- ready  out  1  high when idle and able to accept send.
- dshot_out  out  1  serial DShot line; idles low.
- done  out  1  one-cycle pulse at the end of each frame's gap.
- frame  out  16  last accepted frame {value, telemetry, crc}; for debug and verification.

Behaviour:
- Reset values: ready=1, dshot_out=0, done=0, frame=16'h0000, state=IDLE, all counters 0.
- CRC computation:
  - p = {value, telemetry} (12 bits).
  - crc = (p ^ (p>>4) ^ (p>>8))[3:0].
  - frame = {p, crc}.
- Handshake:
  - Accept occurs when send && ready at clock edge N.
  - At edge N, frame is registered from the current value/telemetry, the bit index is set to 15, and the cycle counter is cleared.
  - From cycle N+1: ready=0 and dshot_out=1 (first bit's high phase starts).
  - send while ready=0 is ignored and not queued; value/telemetry may change freely after the accept.
- State machine (IDLE, BIT, GAP):
  - IDLE: dshot_out=0, ready=1. On accept -> BIT.
  - BIT:
    - cnt runs 0..BIT_CYCLES-1.
    - dshot_out=1 while cnt < (frame[idx] ? T1H_CYCLES : T0H_CYCLES), otherwise 0.
    - At cnt=BIT_CYCLES-1: if idx=0 -> GAP with cnt=0; else idx-1 and cnt=0.
    - Each bit lasts exactly BIT_CYCLES cycles; a frame lasts 16*BIT_CYCLES = 1696 cycles.
  - GAP:
    - dshot_out=0 for GAP_CYCLES cycles.
    - At cnt=GAP_CYCLES-1 -> IDLE. done=1 and ready=1 in the same (first IDLE) cycle.
- Output register: dshot_out is a registered output with no combinational path from inputs.
- Back-to-back frames: if send is held high, the next accept happens on the first IDLE cycle. The next frame's rising edge therefore follows the previous frame's start by exactly 1696+212+1 cycles.
- Reset mid-frame or mid-gap: the next cycle is IDLE with dshot_out=0 and ready=1. No done pulse is issued. frame clears to 0.
- Reset takes priority over a simultaneous send.
- Width rules:
  - Counters are sized for max(BIT_CYCLES, GAP_CYCLES).
  - Parameter constraints: T0H_CYCLES < T1H_CYCLES < BIT_CYCLES, and T0H_CYCLES > BIT_CYCLES/4.
  - The T0H constraint keeps the decoder's first-quarter high check valid.
- No validation of value: commands and throttle are transmitted identically.

Test Plan:
- Throttle frame: value=1046, telemetry=0, single send pulse -> frame=16'h82C6. dshot_out high widths per bit are 80,40,40,40,40,40,80,40,80,80,40,40,40,80,80,40. Each bit period is 106 cycles; done pulses 1908 cycles after the accept cycle.
- Command with telemetry: value=0, telemetry=1 -> frame=16'h0011. Fourteen 40-cycle highs, with 80-cycle highs at bit positions 4 and 0.
- Boundaries:
  - value=2047, telemetry=1 -> frame=16'hFFFF, all sixteen highs are 80 cycles.
  - value=48, telemetry=0 -> frame=16'h0606.
- Handshake: send held high for 5000 cycles -> accepts occur exactly 1909 cycles apart. ready is low for 1908 cycles per frame, and sends asserted while ready=0 are dropped.
- Reset mid-operation: assert reset during bit 7 of a frame -> dshot_out=0 and ready=1 on the next cycle, no done pulse. A fresh send then yields a correct full frame.
- Loopback: drive dshot_out into the existing DShot input decoder with value=1046 -> the decoder reports CRCValid=1, isValidSpeed=1, and setSpeed=998.
